psubsb_serial: RTL and testbench
================================

// Module: psubsb_serial
// PURPOSE
//  Iterative packed saturating add/subtract unit: one signed 4-bit lane per cycle.
//  Multi-cycle companion to the combinational packed saturating adder.
//  Adds the subtract direction (rs - rt per lane) and per-lane saturation flags.
//  Sits in the ALU's multi-cycle path; the controller issues start and stalls until done.
// PARAMETERS
//  LANE_W  4  bits per signed lane
//  LANES   4  lanes per word (data width = LANE_W*LANES = 16)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   request; accepted only in IDLE or DONE
//  op_sub     in   1   0: rs+rt per lane, 1: rs-rt per lane; latched on accept
//  rs         in   16  operand A, latched on accept
//  rt         in   16  operand B, latched on accept
//  busy       out  1   high in RUN
//  done       out  1   one-cycle pulse (state DONE); rd/sat valid from here
//  rd         out  16  packed saturated result, held until next accept
//  sat        out  4   per-lane saturation flag, bit i = lane i clamped
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, lane counter=0, busy=0, done=0, rd=0, sat=0, operand regs=0.
//  FSM: IDLE -start-> RUN; RUN with lane==LANES-1 -> DONE; DONE -start-> RUN, else -> IDLE.
//  Accept edge E0: latch rs, rt, op_sub; clear rd, sat; lane=0; enter RUN.
//  Edges E1..E4 (RUN): compute lane k (k = 0..3, LSB nibble first); write rd[4k+3:4k] and sat[k]; lane++.
//  At E4: enter DONE. done=1 for the cycle after E4. Latency start->done = 4 cycles.
//  Arithmetic per lane:
//   - sign-extend both nibbles to 5 bits; r = a + b, or a - b when op_sub.
//   - r > 7 -> 4'h7, sat=1.
//   - r < -8 -> 4'h8, sat=1.
//   - else r[3:0], sat=0.
//   - Exact boundaries 7 and -8 are not saturation.
//  start while busy: ignored; operands and op_sub are not re-latched.
//  start in DONE: accepted (back-to-back).
//   - done still pulses that cycle.
//   - rd/sat clear at the accept edge.
//  Lane counter never wraps past LANES-1; counter is 2 bits and reset to 0 on every accept.
//  Reset mid-RUN: abort immediately, no done pulse; partial rd discarded (rd=0).
//  Inputs rs/rt/op_sub are don't-care outside the accept cycle.
// STRUCTURE
//  Shared header wisc_defs.vh:
//   - LANE_W, LANES.
//   - FSM state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
//   - SAT_POS=4'h7, SAT_NEG=4'h8.
//  Sub-module sat_lane (combinational), ports a[3:0], b[3:0], sub, y[3:0], ovf.
//   - Single instance, muxed by lane counter.
//   - Reusable by the combinational packed adder.
//  Top: FSM, lane counter, operand regs, result/flag regs.
// TESTING
//  1 add rs=16'h7777 rt=16'h1111 -> after 4 cycles done=1, rd=16'h7777, sat=4'hF.
//  2 sub rs=16'h8888 rt=16'h1111 -> rd=16'h8888, sat=4'hF.
//  3 sub rs=16'h1234 rt=16'h1111 -> rd=16'h0123, sat=4'h0.
//    add rs=16'h9F72 rt=16'hA1F6 -> rd=16'h8067, sat=4'h9.
//  4 start pulsed again on cycle 2 of RUN with new operands -> ignored.
//    Result is that of first op; done exactly once.
//  5 rst asserted mid-RUN after lane 1 -> same cycle busy=0, rd=0, sat=0.
//    No done; the next start completes normally.
//  6 start held high through DONE with new op -> done pulse, then immediately busy=1.
//    Second result correct 4 cycles later.

Source files
------------

// File: rtl/psubsb_serial_pkg.sv
// psubsb_serial_pkg
//   Shared constants for the serial packed saturating add/subtract unit:
//   - lane geometry
//   - FSM state encodings
//   - saturation clamp values
//   Imported by psubsb_serial and sat_lane.
package psubsb_serial_pkg;

    localparam int LANE_W = 4;               // bits per signed lane
    localparam int LANES  = 4;               // lanes per packed word
    localparam int DATA_W = LANE_W * LANES;  // packed word width

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Clamp values for a signed 4-bit lane
    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

    // Index of the final lane; reaching it in RUN ends the operation
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

endpackage

// File: rtl/psubsb_serial_sat_lane.sv
// sat_lane
//   Combinational saturating add/subtract of one signed 4-bit lane.
//   Ports:
//     a, b : signed lane operands
//     sub  : 0 selects a+b, 1 selects a-b
//     y    : clamped result
//     ovf  : result was clamped
//   The exact limits +7 and -8 are representable and are not flagged.
module sat_lane
    import psubsb_serial_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sub,
    output logic [LANE_W-1:0] y,
    output logic              ovf
);

    logic signed [LANE_W:0] a_ext;
    logic signed [LANE_W:0] b_ext;
    logic signed [LANE_W:0] sum;

    // One guard bit holds the full range of a 4-bit sum or difference
    // (-16..15), so there is no wrap before the range test.
    assign a_ext = $signed({a[LANE_W-1], a});
    assign b_ext = $signed({b[LANE_W-1], b});
    assign sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);

    always_comb begin
        y   = sum[LANE_W-1:0];
        ovf = 1'b0;
        if (sum > 5'sd7) begin
            y   = SAT_POS;
            ovf = 1'b1;
        end else if (sum < -5'sd8) begin
            y   = SAT_NEG;
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/psubsb_serial.sv
// psubsb_serial
//   Iterative packed saturating add/subtract unit. It processes one signed
//   4-bit lane per clock cycle, starting with the least-significant nibble.
//   Ports:
//     clk, rst : rising-edge clock, asynchronous active-high reset
//     start    : request, taken only in IDLE or DONE
//     op_sub   : 0 adds, 1 subtracts (rs - rt); latched on accept
//     rs, rt   : packed operands, latched on accept
//     busy     : high while lanes are being computed
//     done     : one-cycle completion pulse
//     rd       : packed saturated result, held until the next accept
//     sat      : per-lane clamp flags
//   Latency from the accept edge to done is 4 cycles.
//   A start that arrives in DONE is accepted back-to-back.
module psubsb_serial
    import psubsb_serial_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd,
    output logic [LANES-1:0]  sat
);

    logic [1:0]        state_reg;
    logic [1:0]        lane_reg;
    logic [DATA_W-1:0] rs_reg;
    logic [DATA_W-1:0] rt_reg;
    logic              sub_reg;
    logic [DATA_W-1:0] rd_reg;
    logic [LANES-1:0]  sat_reg;

    // Latched operands split into lane nibbles for the lane-select mux
    logic [LANE_W-1:0] rs_lane [LANES];
    logic [LANE_W-1:0] rt_lane [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_split
            assign rs_lane[gi] = rs_reg[gi*LANE_W +: LANE_W];
            assign rt_lane[gi] = rt_reg[gi*LANE_W +: LANE_W];
        end
    endgenerate

    logic [LANE_W-1:0] lane_y;
    logic              lane_ovf;

    // Single shared lane datapath, stepped across the word by lane_reg
    sat_lane u_sat_lane (
        .a   (rs_lane[lane_reg]),
        .b   (rt_lane[lane_reg]),
        .sub (sub_reg),
        .y   (lane_y),
        .ovf (lane_ovf)
    );

    logic accept;
    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            lane_reg  <= 2'd0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            sub_reg   <= 1'b0;
            rd_reg    <= '0;
            sat_reg   <= '0;
        end else if (accept) begin
            // Results from the previous operation are cleared as the new one starts
            state_reg <= ST_RUN;
            lane_reg  <= 2'd0;
            rs_reg    <= rs;
            rt_reg    <= rt;
            sub_reg   <= op_sub;
            rd_reg    <= '0;
            sat_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    rd_reg[lane_reg*LANE_W +: LANE_W] <= lane_y;
                    sat_reg[lane_reg]                 <= lane_ovf;
                    // The counter holds at the last lane and does not wrap
                    if (lane_reg == LAST_LANE) begin
                        state_reg <= ST_DONE;
                    end else begin
                        lane_reg <= lane_reg + 2'd1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                ST_IDLE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign rd   = rd_reg;
    assign sat  = sat_reg;

endmodule

// File: tb/tb_psubsb_serial.sv
// tb_psubsb_serial
//   Directed, table-driven bench for psubsb_serial.
//   Each table row is a complete operation with a hand-computed result.
//   Hand-written sequences cover:
//   - start while busy
//   - reset during RUN
//   - back-to-back accept from DONE
module tb_psubsb_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [15:0] rs;
    logic [15:0] rt;
    logic        busy;
    logic        done;
    logic [15:0] rd;
    logic [3:0]  sat;

    int n_applied = 0;
    int n_miscmp  = 0;

    psubsb_serial dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .rs     (rs),
        .rt     (rt),
        .busy   (busy),
        .done   (done),
        .rd     (rd),
        .sat    (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        op_sub;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] exp_rd;
        logic [3:0]  exp_sat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits up to 12 edges for done; sampling is 1 time unit after each edge
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 12);
    endtask

    task automatic issue(input logic sub_i, input logic [15:0] rs_i, input logic [15:0] rt_i);
        @(negedge clk);
        start  = 1'b1;
        op_sub = sub_i;
        rs     = rs_i;
        rt     = rt_i;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        issue(v.op_sub, v.rs, v.rt);
        wait_done(cyc);
        check({v.name, " latency"}, 32'(cyc), 32'd4);
        check({v.name, " done"}, 32'(done), 32'd1);
        check({v.name, " rd"}, 32'(rd), 32'(v.exp_rd));
        check({v.name, " sat"}, 32'(sat), 32'(v.exp_sat));
        $display("vec %-12s sub=%0d rs=%h rt=%h -> rd=%h sat=%h (exp %h/%h) lat=%0d",
                 v.name, v.op_sub, v.rs, v.rt, rd, sat, v.exp_rd, v.exp_sat, cyc);
    endtask

    initial begin
        int cyc;
        int n_done;

        vecs[0] = '{"add7777",   1'b0, 16'h7777, 16'h1111, 16'h7777, 4'hF};
        vecs[1] = '{"sub8888",   1'b1, 16'h8888, 16'h1111, 16'h8888, 4'hF};
        vecs[2] = '{"sub1234",   1'b1, 16'h1234, 16'h1111, 16'h0123, 4'h0};
        vecs[3] = '{"add9F72",   1'b0, 16'h9F72, 16'hA1F6, 16'h8067, 4'h9};
        vecs[4] = '{"add_exact7",1'b0, 16'h4444, 16'h3333, 16'h7777, 4'h0};
        vecs[5] = '{"sub_exactm8",1'b1,16'hCCCC, 16'h4444, 16'h8888, 4'h0};
        vecs[6] = '{"add_neg16", 1'b0, 16'h8888, 16'h8888, 16'h8888, 4'hF};
        vecs[7] = '{"sub_mixed", 1'b1, 16'h7F08, 16'h8170, 16'h7E98, 4'h8};
        vecs[8] = '{"add1234",   1'b0, 16'h1234, 16'h4321, 16'h5555, 4'h0};

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; rs = '0; rt = '0;
        #2;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd",   32'(rd),   32'd0);
        check("reset sat",  32'(sat),  32'd0);
        $display("reset: busy=%0d done=%0d rd=%h sat=%h", busy, done, rd, sat);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            @(posedge clk);
            #1;
            check({vecs[i].name, " done_clear"}, 32'(done), 32'd0);
        end

        // A start pulsed during RUN with new operands is ignored
        issue(1'b1, 16'h1234, 16'h1111);
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; rs = 16'h7777; rt = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                check("busy_ign rd",  32'(rd),  32'h0123);
                check("busy_ign sat", 32'(sat), 32'h0);
            end
        end
        check("busy_ign done_count", 32'(n_done), 32'd1);
        check("busy_ign idle", 32'(busy), 32'd0);
        $display("busy-start: done pulses=%0d rd=%h sat=%h", n_done, rd, sat);

        // Reset after lanes 0 and 1 have been written
        issue(1'b0, 16'h7777, 16'h1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst partial rd",  32'(rd),  32'h0077);
        check("mid_rst partial sat", 32'(sat), 32'h3);
        rst = 1'b1;
        #1;
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst rd",   32'(rd),   32'd0);
        check("mid_rst sat",  32'(sat),  32'd0);
        check("mid_rst done", 32'(done), 32'd0);
        $display("mid-run reset: busy=%0d rd=%h sat=%h", busy, rd, sat);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("mid_rst no_done", 32'(n_done), 32'd0);
        run_vec(vecs[3]);

        // start held high from RUN into DONE, with the second op presented
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; rs = 16'h7777; rt = 16'h1111;
        @(posedge clk);
        #1;
        op_sub = 1'b1; rs = 16'h1234; rt = 16'h1111;
        wait_done(cyc);
        check("b2b first latency", 32'(cyc), 32'd4);
        check("b2b first rd",  32'(rd),  32'h7777);
        check("b2b first sat", 32'(sat), 32'hF);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b rebusy", 32'(busy), 32'd1);
        check("b2b redone", 32'(done), 32'd0);
        check("b2b clear rd",  32'(rd),  32'd0);
        check("b2b clear sat", 32'(sat), 32'd0);
        wait_done(cyc);
        check("b2b second latency", 32'(cyc), 32'd4);
        check("b2b second rd",  32'(rd),  32'h0123);
        check("b2b second sat", 32'(sat), 32'h0);
        $display("back-to-back: second rd=%h sat=%h lat=%0d", rd, sat, cyc);
        @(posedge clk);
        #1;
        check("b2b final idle", 32'(busy | done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule
